audio_pwm_out: RTL



---
 rtl/audio_pwm_out.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/audio_pwm_out.sv
// Final audio stage: sample-rate tick, mute fade FSM, volume shift and 256-clock PWM DAC.
// Samples are captured from the upstream sine-sum block and applied to the PWM one period at a time.
module audio_pwm_out #(
    parameter int CLK_HZ     = 100_000_000,
    parameter int SAMPLE_HZ  = 8_000,
    parameter int FADE_STEPS = 16
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic [7:0] sample_in,
    input  logic       sample_valid_in,
    input  logic [2:0] volume_in,
    input  logic       mute_in,
    output logic       step_out,
    output logic       pwm_out,
    output logic [7:0] sample_latched_out,
    output logic       fade_busy_out,
    output logic       stale_out
);

    localparam int TICK_DIV  = CLK_HZ / SAMPLE_HZ;
    localparam int CNT_W     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int FADE_LOG2 = $clog2(FADE_STEPS);
    localparam int GAIN_W    = FADE_LOG2 + 1;
    localparam int PROD_W    = 8 + GAIN_W + 1;

    localparam logic [CNT_W-1:0]  TICK_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [GAIN_W-1:0] GAIN_MAX  = GAIN_W'(FADE_STEPS);

    localparam logic [1:0] MUTED    = 2'd0;
    localparam logic [1:0] FADE_IN  = 2'd1;
    localparam logic [1:0] PLAY     = 2'd2;
    localparam logic [1:0] FADE_OUT = 2'd3;

    logic [CNT_W-1:0]   tick_cnt;
    logic               tick;
    logic               tick_d;
    logic [7:0]         staging;
    logic signed [7:0]  active;
    logic               seen_valid;
    logic [1:0]         state;
    logic [1:0]         state_next;
    logic [GAIN_W-1:0]  gain;
    logic [GAIN_W-1:0]  gain_next;
    logic signed [PROD_W-1:0] active_x;
    logic signed [PROD_W-1:0] gain_x;
    logic signed [PROD_W-1:0] product;
    logic [7:0]         scaled;
    logic [7:0]         pwm_cnt;
    logic [7:0]         duty;
    logic [7:0]         duty_next;

    assign tick     = (tick_cnt == TICK_LAST);
    assign step_out = tick;

    // Gain is at most FADE_STEPS, so the shifted product always fits back into 8 signed bits.
    assign active_x = PROD_W'(active);
    assign gain_x   = PROD_W'({1'b0, gain});
    assign product  = active_x * gain_x;
    assign scaled   = 8'((product >>> FADE_LOG2) >>> volume_in);

    always_comb begin
        state_next = state;
        gain_next  = gain;
        case (state)
            MUTED: begin
                gain_next = '0;
                if (!mute_in) state_next = FADE_IN;
            end
            FADE_IN: begin
                // A reversal with gain already on the rail lands directly in the rest state.
                if (mute_in) begin
                    state_next = (gain == '0) ? MUTED : FADE_OUT;
                end else begin
                    if (gain != GAIN_MAX) gain_next = gain + GAIN_W'(1);
                    if (gain_next == GAIN_MAX) state_next = PLAY;
                end
            end
            PLAY: begin
                gain_next = GAIN_MAX;
                if (mute_in) state_next = FADE_OUT;
            end
            FADE_OUT: begin
                if (!mute_in) begin
                    state_next = (gain == GAIN_MAX) ? PLAY : FADE_IN;
                end else begin
                    if (gain != '0) gain_next = gain - GAIN_W'(1);
                    if (gain_next == '0) state_next = MUTED;
                end
            end
            default: begin
                state_next = MUTED;
                gain_next  = '0;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            tick_cnt           <= '0;
            tick_d             <= 1'b0;
            staging            <= '0;
            active             <= '0;
            seen_valid         <= 1'b0;
            state              <= MUTED;
            gain               <= '0;
            stale_out          <= 1'b0;
            fade_busy_out      <= 1'b0;
            sample_latched_out <= '0;
            duty_next          <= 8'h80;
            duty               <= 8'h80;
            pwm_cnt            <= '0;
            pwm_out            <= 1'b0;
        end else begin
            tick_cnt <= tick ? '0 : tick_cnt + CNT_W'(1);
            tick_d   <= tick;

            if (sample_valid_in) staging <= sample_in;
            seen_valid <= tick ? 1'b0 : (seen_valid | sample_valid_in);

            if (tick) begin
                active        <= staging;
                stale_out     <= ~(seen_valid | sample_valid_in);
                state         <= state_next;
                gain          <= gain_next;
                fade_busy_out <= (state_next == FADE_IN) || (state_next == FADE_OUT);
            end

            if (tick_d) begin
                sample_latched_out <= scaled;
                duty_next          <= {~scaled[7], scaled[6:0]};
            end

            // Duty only changes at the period boundary so each PWM period is glitch-free.
            pwm_cnt <= pwm_cnt + 8'd1;
            if (pwm_cnt == 8'hFF) duty <= duty_next;
            pwm_out <= (pwm_cnt < duty);
        end
    end

endmodule
